// File: rtl/rv_mem_pkg.sv
// Shared types and constants for the instruction memory with boot/loader engine.
package rv_mem_pkg;

    // RISC-V canonical NOP (addi x0, x0, 0).
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Engine state: zero-fill after reset, normal fetch service, program load.
    typedef enum logic [1:0] {
        IMEM_CLEAR,
        IMEM_RUN,
        IMEM_LOAD
    } imem_state_e;

    // Source of the fetch output for the current cycle, chosen one cycle earlier.
    typedef enum logic [1:0] {
        FETCH_NOP,
        FETCH_RAM,
        FETCH_HOLD
    } fetch_sel_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Host-side program load stream: start pulse plus a valid/ready word channel.
interface instr_mem_loader_if #(
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    logic          load_start;
    logic [AW-1:0] load_base;
    logic          load_valid;
    logic [31:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic [AW:0]   load_count;

    // Host loader (UART bridge, testbench) drives the stream.
    modport master (
        output load_start, load_base, load_valid, load_data, load_last,
        input  load_ready, load_count
    );

    // Memory engine consumes the stream.
    modport slave (
        input  load_start, load_base, load_valid, load_data, load_last,
        output load_ready, load_count
    );
endinterface

// File: rtl/imem_ram_1w1r.sv
// Word-addressed storage: one synchronous write port and one registered read port.
// A read and write of the same word in one cycle returns the old contents.
module imem_ram_1w1r #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write on request, read every cycle into the output register.
    // NOTE: the array has no reset so it maps onto block RAM; zeroing is the
    // CLEAR walk in the parent, and non-blocking writes give read-first ordering.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with boot engine: zero-fills after reset, accepts a program
// over the load stream, then serves single-cycle-latency fetches to the IF stage.
module instr_mem_loader
    import rv_mem_pkg::*;
#(
    parameter int DEPTH          = 256,
    parameter bit STALL_HOLD     = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [31:0]        addr,
    output logic [31:0]        data,
    output logic               fetch_fault,
    output logic               busy,
    instr_mem_loader_if.slave  ld
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [AW-1:0] IDX_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] IDX_INC   = AW'(1);
    localparam logic [AW:0]   COUNT_MAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_INC = (AW + 1)'(1);

    imem_state_e   state_q;
    logic [AW-1:0] clr_idx_q;
    logic [AW-1:0] wr_idx_q;
    logic          load_ready_q;
    logic [AW:0]   load_count_q;
    logic          load_accept;

    fetch_sel_e    sel_d, sel_q;
    logic          fault_d, fault_q;
    logic [31:0]   hold_q;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;
    logic          addr_misaligned;
    logic          addr_out_of_range;

    assign load_accept = ld.load_valid && load_ready_q;

    // Engine FSM: clear walk, idle run, load stream; ready and count are registered.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= CLEAR_ON_RESET ? IMEM_CLEAR : IMEM_RUN;
            clr_idx_q    <= '0;
            wr_idx_q     <= '0;
            load_ready_q <= 1'b0;
            load_count_q <= '0;
        end else begin
            case (state_q)
                IMEM_CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDX_INC;
                    if (clr_idx_q == IDX_LAST) begin
                        state_q <= IMEM_RUN;
                    end
                end
                IMEM_RUN: begin
                    if (ld.load_start) begin
                        state_q      <= IMEM_LOAD;
                        wr_idx_q     <= ld.load_base;
                        load_count_q <= '0;
                        load_ready_q <= 1'b1;
                    end
                end
                IMEM_LOAD: begin
                    if (load_accept) begin
                        // Index wraps modulo DEPTH by its width.
                        wr_idx_q <= wr_idx_q + IDX_INC;
                        if (load_count_q != COUNT_MAX) begin
                            load_count_q <= load_count_q + COUNT_INC;
                        end
                        if (ld.load_last) begin
                            state_q      <= IMEM_RUN;
                            load_ready_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q      <= IMEM_RUN;
                    load_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = (state_q != IMEM_RUN);
    assign ld.load_ready = load_ready_q;
    assign ld.load_count = load_count_q;

    // Write port mux: zero fill during CLEAR, accepted stream words during LOAD.
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr_idx_q;
        ram_wdata = ld.load_data;
        case (state_q)
            IMEM_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_idx_q;
                ram_wdata = '0;
            end
            IMEM_LOAD: begin
                ram_we = load_accept;
            end
            default: ;
        endcase
    end

    imem_ram_1w1r #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (addr[AW+1:2]),
        .rdata_o (ram_rdata)
    );

    assign addr_misaligned   = (addr[1:0] != 2'b00);
    assign addr_out_of_range = (addr[31:2] >= 30'(DEPTH));

    // Fetch decision for next cycle: busy, then stall, then address fault, then RAM.
    always_comb begin
        sel_d   = FETCH_NOP;
        fault_d = fault_q;
        if (busy) begin
            sel_d   = FETCH_NOP;
            fault_d = 1'b0;
        end else if (stall) begin
            sel_d = STALL_HOLD ? FETCH_HOLD : FETCH_NOP;
        end else if (addr_misaligned || addr_out_of_range) begin
            sel_d   = FETCH_NOP;
            fault_d = 1'b1;
        end else begin
            sel_d   = FETCH_RAM;
            fault_d = 1'b0;
        end
    end

    // Fetch registers: output select, fault flag, and a copy of the last output word.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= FETCH_NOP;
            fault_q <= 1'b0;
            hold_q  <= RV_NOP;
        end else begin
            sel_q   <= sel_d;
            fault_q <= fault_d;
            hold_q  <= data;
        end
    end

    // Output word is a select among registered sources only.
    always_comb begin
        case (sel_q)
            FETCH_RAM:  data = ram_rdata;
            FETCH_HOLD: data = hold_q;
            default:    data = RV_NOP;
        endcase
    end

    assign fetch_fault = fault_q;

endmodule
